// File: rtl/pc_next_unit.sv
// Program-counter stage for the single-cycle MIPS datapath: next-PC selection,
// PC register, misaligned-jr trap and saturating bring-up counters.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_0180,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [31:0]      signimmsh,
  input  logic [25:0]      instr_idx,
  input  logic [31:0]      rs_data,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  input  logic             clr_stats,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  output logic             misaligned,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pcbranch;
  logic [31:0] pcjump;
  logic [31:0] pc_next;
  logic        trap;
  logic        taken;

  // All target arithmetic is mod 2^32; carries out of bit 31 are dropped.
  assign pcplus4  = pc + 32'd4;
  assign pcbranch = pcplus4 + signimmsh;
  assign pcjump   = {pcplus4[31:28], instr_idx, 2'b00};
  assign trap     = jr && (rs_data[1:0] != 2'b00);

  // NOTE: defaults first so every path assigns every output -- no latch.
  always_comb begin
    pc_next = pcplus4;
    taken   = 1'b0;
    if (trap) begin
      pc_next = EXC_PC;
    end else if (jr) begin
      pc_next = rs_data;
      taken   = 1'b1;
    end else if (jump) begin
      pc_next = pcjump;
      taken   = 1'b1;
    end else if (branch && zero) begin
      pc_next = pcbranch;
      taken   = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
      instr_cnt  <= '0;
      taken_cnt  <= '0;
    end else begin
      if (en) begin
        pc         <= pc_next;
        misaligned <= trap;
      end
      // Clearing the statistics overrides the stall and drops this edge's increment.
      if (clr_stats) begin
        instr_cnt <= '0;
        taken_cnt <= '0;
      end else if (en) begin
        if (instr_cnt != CNT_MAX) instr_cnt <= instr_cnt + CNT_ONE;
        if (taken && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: per-feature stimulus tables with a
// queue of expected results popped after each clock edge.
module tb_pc_next_unit;

  typedef struct packed {
    logic        rst, en, br, z, j, jr, clr;
    logic [31:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic        mis;
    logic [15:0] ic;
    logic [15:0] tc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, en, branch, zero, jump, jr, clr_stats;
  logic [31:0] signimmsh, rs_data;
  logic [25:0] instr_idx;
  logic [31:0] pc, pcplus4, pc4, pcplus4_4;
  logic        misaligned, misaligned4;
  logic [15:0] instr_cnt, taken_cnt;
  logic [3:0]  instr_cnt4, taken_cnt4;
  obs_t        obs;
  obs_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk(clk), .reset(reset), .en(en), .signimmsh(signimmsh), .instr_idx(instr_idx),
    .rs_data(rs_data), .branch(branch), .zero(zero), .jump(jump), .jr(jr),
    .clr_stats(clr_stats), .pc(pc), .pcplus4(pcplus4), .misaligned(misaligned),
    .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
  );

  pc_next_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .signimmsh(signimmsh), .instr_idx(instr_idx),
    .rs_data(rs_data), .branch(branch), .zero(zero), .jump(jump), .jr(jr),
    .clr_stats(clr_stats), .pc(pc4), .pcplus4(pcplus4_4), .misaligned(misaligned4),
    .instr_cnt(instr_cnt4), .taken_cnt(taken_cnt4)
  );

  assign obs = {pc, pcplus4, misaligned, instr_cnt, taken_cnt};

  function automatic stim_t st(input logic rst, input logic e, input logic b, input logic z,
                               input logic j, input logic r, input logic c,
                               input logic [31:0] imm, input logic [25:0] idx,
                               input logic [31:0] rs);
    return {rst, e, b, z, j, r, c, imm, idx, rs};
  endfunction

  function automatic obs_t ex(input logic [31:0] p, input logic m,
                              input logic [15:0] ic, input logic [15:0] tc);
    return {p, p + 32'd4, m, ic, tc};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h pc4=%h mis=%b ic=%0d tc=%0d", o.pc, o.pp4, o.mis, o.ic, o.tc);
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; en = s.en; branch = s.br; zero = s.z; jump = s.j; jr = s.jr;
    clr_stats = s.clr; signimmsh = s.imm; instr_idx = s.idx; rs_data = s.rs;
  endtask

  task automatic test_reset();
    stim_t s[5];
    obs_t  e[5];
    obs_t  w;
    s[0] = st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  e[0] = ex(32'h0, 0, 0, 0);
    s[1] = st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  e[1] = ex(32'h0, 0, 0, 0);
    s[2] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  e[2] = ex(32'h4, 0, 1, 0);
    s[3] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  e[3] = ex(32'h8, 0, 2, 0);
    s[4] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  e[4] = ex(32'hC, 0, 3, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_branch();
    stim_t s[4];
    obs_t  e[4];
    obs_t  w;
    s[0] = st(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h100);            e[0] = ex(32'h100, 0, 4, 1);
    s[1] = st(0, 1, 1, 1, 0, 0, 0, 32'hFFFF_FFF0, 0, 0);      e[1] = ex(32'hF4,  0, 5, 2);
    s[2] = st(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h100);            e[2] = ex(32'h100, 0, 6, 3);
    s[3] = st(0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0);      e[3] = ex(32'h104, 0, 7, 3);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_jump();
    stim_t s[4];
    obs_t  e[4];
    obs_t  w;
    s[0] = st(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h1000_0000);      e[0] = ex(32'h1000_0000, 0, 8, 4);
    s[1] = st(0, 1, 0, 0, 1, 0, 0, 0, 26'h40, 0);             e[1] = ex(32'h1000_0100, 0, 9, 5);
    s[2] = st(0, 1, 0, 0, 1, 1, 0, 0, 26'h40, 32'h200);       e[2] = ex(32'h200, 0, 10, 6);
    s[3] = st(0, 1, 1, 1, 1, 0, 0, 32'h40, 26'h3, 0);         e[3] = ex(32'hC, 0, 11, 7);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL jump[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_trap();
    stim_t s[5];
    obs_t  e[5];
    obs_t  w;
    s[0] = st(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h203);            e[0] = ex(32'h180, 1, 12, 7);
    s[1] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);                  e[1] = ex(32'h184, 0, 13, 7);
    s[2] = st(0, 1, 0, 0, 1, 1, 0, 0, 26'h40, 32'h201);       e[2] = ex(32'h180, 1, 14, 7);
    s[3] = st(0, 1, 1, 1, 0, 1, 0, 32'h8, 0, 32'h202);        e[3] = ex(32'h180, 1, 15, 7);
    s[4] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);                  e[4] = ex(32'h184, 0, 16, 7);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL trap[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[7];
    obs_t  e[7];
    obs_t  w;
    for (int i = 0; i < 4; i++) begin
      s[i] = st(0, 0, 0, 0, 1, 0, 0, 0, 26'h40, 0);
      e[i] = ex(32'h184, 0, 16, 7);
    end
    s[4] = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);                  e[4] = ex(32'h184, 0, 0, 0);
    s[5] = st(0, 1, 0, 0, 1, 0, 1, 0, 26'h40, 0);             e[5] = ex(32'h100, 0, 0, 0);
    s[6] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);                  e[6] = ex(32'h104, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[5];
    obs_t  e[5];
    obs_t  w;
    s[0] = st(0, 1, 1, 1, 0, 0, 0, 32'h8, 0, 0);              e[0] = ex(32'h110, 0, 2, 1);
    s[1] = st(0, 1, 1, 1, 0, 0, 0, 32'h8, 0, 0);              e[1] = ex(32'h11C, 0, 3, 2);
    s[2] = st(1, 1, 0, 0, 1, 1, 0, 0, 26'h10, 32'h40);        e[2] = ex(32'h0, 0, 0, 0);
    s[3] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);                  e[3] = ex(32'h4, 0, 1, 0);
    s[4] = st(1, 0, 1, 1, 0, 0, 0, 32'h8, 0, 0);              e[4] = ex(32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[4];
    obs_t  e[4];
    obs_t  w;
    s[0] = st(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);      e[0] = ex(32'hFFFF_FFFC, 0, 1, 1);
    s[1] = st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);                  e[1] = ex(32'h0, 0, 2, 1);
    s[2] = st(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0);      e[2] = ex(32'hFFFF_FFF0, 0, 3, 2);
    s[3] = st(0, 1, 1, 1, 0, 0, 0, 32'h20, 0, 0);             e[3] = ex(32'h14, 0, 4, 3);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      w = sb.pop_front();
      n_tests++;
      if (obs !== w) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(obs), fmt(w));
      end
    end
  endtask

  task automatic test_saturation();
    obs_t       w;
    logic [3:0] sat;
    apply(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(ex(32'h0, 0, 0, 0));
    @(posedge clk); #1;
    w = sb.pop_front();
    n_tests++;
    if (obs !== w || instr_cnt4 !== 4'd0 || taken_cnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_reset: got %s ic4=%0d tc4=%0d, want %s ic4=0 tc4=0",
               fmt(obs), instr_cnt4, taken_cnt4, fmt(w));
    end
    for (int i = 0; i < 20; i++) begin
      apply(st(0, 1, 1, 1, 0, 0, 0, 32'h4, 0, 0));
      sb.push_back(ex(32'(8 * (i + 1)), 0, 16'(i + 1), 16'(i + 1)));
      @(posedge clk); #1;
      w   = sb.pop_front();
      sat = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      n_tests++;
      if (obs !== w || instr_cnt4 !== sat || taken_cnt4 !== sat || pc4 !== w.pc) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %s ic4=%0d tc4=%0d pc4=%h, want %s ic4=%0d tc4=%0d",
                 i, fmt(obs), instr_cnt4, taken_cnt4, pc4, fmt(w), sat, sat);
      end
    end
  endtask

  initial begin
    apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_branch();
    test_jump();
    test_trap();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage of the single-cycle MIPS datapath. Directly consumes the word-shifted branch offset produced by the shift-left-2 block, and owns the PC register.
- Computes PC+4, the branch target, the jump target and the register-jump target. Selects the next PC, updates it on each enabled clock edge and traps misaligned register-jump targets.
- Also provides saturating counters for retired instructions and taken control transfers, used for bring-up statistics.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_PC, 32'h0000_0180, PC loaded when a misaligned jr target is trapped.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  PC update enable; 0 = stall, hold all state.
- signimmsh  input  32  sign-extended immediate already shifted left 2 (output of the sl2 block).
- instr_idx  input  26  instr[25:0], J-type target field.
- rs_data  input  32  register value for jr.
- branch  input  1  beq-class instruction in flight.
- zero  input  1  ALU zero flag.
- jump  input  1  j/jal instruction.
- jr  input  1  jr instruction.
- clr_stats  input  1  synchronous clear of both counters.
- pc  output  32  current PC (registered).
- pcplus4  output  32  pc + 4 (combinational from pc).
- misaligned  output  1  registered flag, high for one cycle after a trapped jr.
- instr_cnt  output  CNT_W  enabled cycles retired, saturating.
- taken_cnt  output  CNT_W  taken branches/jumps/jr, saturating.

Behaviour:
- Reset (synchronous, has priority over everything): pc=RESET_PC, misaligned=0, instr_cnt=0, taken_cnt=0. pcplus4 therefore reads RESET_PC+4 in the cycle after reset.
- Targets, all computed combinationally and mod 2^32 (carries out of bit 31 are dropped, so wrap-around is silent):
  - pcbranch = pcplus4 + signimmsh.
  - pcjump = {pcplus4[31:28], instr_idx, 2'b00}.
  - pcjr = rs_data.
- Next-PC priority, highest first:
  1. jr with rs_data[1:0]!=0 -> EXC_PC, set misaligned.
  2. jr -> pcjr.
  3. jump -> pcjump.
  4. branch & zero -> pcbranch.
  5. otherwise -> pcplus4.
- Simultaneous control inputs resolve strictly by the priority above; no error is flagged for illegal combinations.
- Latency: pc takes the selected value on the clock edge at which en=1, i.e. one cycle from the control inputs.
- en=0: pc, the counters and misaligned all hold. misaligned is not re-asserted during a stall.
- misaligned: set for exactly one enabled cycle on the trapping edge; cleared on the next enabled edge unless a new trap occurs.
- instr_cnt: +1 on every enabled edge; saturates at all-ones.
- taken_cnt: +1 when the selected next PC is not pcplus4 through items 2–4. The trap (item 1) does not count. Saturates at all-ones.
- clr_stats=1 on an edge: both counters go to 0, regardless of en; that increment is discarded. pc and misaligned update normally.
- Reset asserted mid-stall or on the same edge as jr/jump/branch: reset wins, and no counter increments.

Test Plan:
- reset 2 cycles, en=1, no control for 3 cycles -> pc 0,4,8,C; instr_cnt=3; taken_cnt=0.
- pc=0x100, branch=1, zero=1, signimmsh=0xFFFF_FFF0 -> next pc=0xF4; taken_cnt+1. Same stimulus with zero=0 -> pc=0x104.
- pc=0x1000_0000, jump=1, instr_idx=0x000_0040 -> pc=0x1000_0100. Add jr=1 with rs_data=0x200 on the same cycle -> pc=0x200 (jr wins).
- jr=1, rs_data=0x203 -> pc=0x180, misaligned=1 for one cycle, taken_cnt unchanged.
- en=0 for 4 cycles with jump=1 -> pc and counters frozen. clr_stats=1 with en=0 -> both counters 0.
- CNT_W=4, 20 enabled cycles with branch taken each cycle -> instr_cnt=taken_cnt=15 (saturated). pc=0xFFFF_FFFC with no control -> pc wraps to 0x0000_0000.
